// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory loader.
// Accepts a length byte followed by big-endian 32-bit words over a byte
// valid/ready stream. Each word is written to instruction memory one cycle
// after its last byte arrives. The CPU is held in reset until a load completes.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte that must match all data bytes before the load counts as done.
module imem_loader #(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   localparam int         IDX_W   = $clog2(DEPTH) + 1;
   localparam logic [8:0] DEPTH_L = 9'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [IDX_W-1:0]  word_idx_q, word_idx_d;
   logic [IDX_W-1:0]  len_q, len_d;
   logic [31:0]       asm_q, asm_d;
   logic              wr_en_q, wr_en_d;
   logic [31:0]       wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        xor_q, xor_d;
`endif

   // State, assembly and write-port registers; reset discards any partial load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= '0;
         word_idx_q <= '0;
         len_q      <= '0;
         asm_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         word_idx_q <= word_idx_d;
         len_q      <= len_d;
         asm_q      <= asm_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q      <= xor_d;
`endif
      end
   end

   // Next-state logic, byte assembly and status outputs decoded from state.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      word_idx_d = word_idx_q;
      len_d      = len_q;
      asm_d      = asm_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_d      = xor_q;
`endif
      in_ready   = 1'b0;
      cpu_hold   = 1'b1;
      done       = 1'b0;
      error      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LEN;
         end
         S_LEN: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_data == 8'd0 || {1'b0, in_data} > DEPTH_L) begin
                  state_d = S_ERROR;
               end else begin
                  len_d      = IDX_W'(in_data);
                  word_idx_d = '0;
                  byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  xor_d      = '0;
`endif
                  state_d    = S_DATA;
               end
            end
         end
         S_DATA: begin
            in_ready = 1'b1;
            if (in_valid) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               xor_d      = xor_q ^ in_data;
`endif
               case (byte_cnt_q)
                  2'd0: asm_d[31:24] = in_data;
                  2'd1: asm_d[23:16] = in_data;
                  2'd2: asm_d[15:8]  = in_data;
                  default: begin
                     // Fourth byte: register the full word for next cycle's write.
                     wr_en_d    = 1'b1;
                     wr_addr_d  = 32'({word_idx_q, 2'b00});
                     wr_data_d  = {asm_q[31:8], in_data};
                     word_idx_d = word_idx_q + 1'b1;
                     if (word_idx_q == len_q - 1'b1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                     end
                  end
               endcase
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            in_ready = 1'b1;
            if (in_valid) state_d = (in_data == xor_q) ? S_DONE : S_ERROR;
         end
`endif
         S_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
            if (start) state_d = S_LEN;
         end
         S_ERROR: begin
            error = 1'b1;
            if (start) state_d = S_LEN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader with a stream-level model.
// The model derives every expected output from the bytes accepted since the
// last honoured start; a per-cycle compare checks the DUT against it, and
// literal expectations after each scenario pin the model itself.
module tb_imem_loader;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;

   imem_loader #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   // ---------------- stream-level model ----------------
   logic [7:0]  mq[$];
   logic        m_active, m_done, m_err, m_wr_en;
   logic [31:0] m_addr, m_data;

   task automatic m_clear();
      mq.delete();
      m_active = 1'b0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_wr_en  = 1'b0;
      m_addr   = '0;
      m_data   = '0;
   endtask

   initial begin
      int         len, n;
      logic [7:0] x;
      m_clear();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_clear();
         end else begin
            m_wr_en = 1'b0;
            if (!m_active) begin
               if (start) begin
                  m_active = 1'b1;
                  mq.delete();
                  m_done = 1'b0;
                  m_err  = 1'b0;
               end
            end else if (in_valid) begin
               mq.push_back(in_data);
               len = int'(mq[0]);
               n   = mq.size() - 1;
               if (n == 0) begin
                  if (len == 0 || len > DEPTH) begin
                     m_active = 1'b0;
                     m_err    = 1'b1;
                  end
               end else begin
                  if (n <= 4 * len && n % 4 == 0) begin
                     m_wr_en = 1'b1;
                     m_addr  = 32'((n / 4 - 1) * 4);
                     m_data  = {mq[n-3], mq[n-2], mq[n-1], mq[n]};
                  end
`ifdef IMEM_LOADER_CHECKSUM_EN
                  if (n == 4 * len + 1) begin
                     x = 8'h00;
                     for (int k = 1; k <= 4 * len; k++) x = x ^ mq[k];
                     m_active = 1'b0;
                     if (x == mq[n]) m_done = 1'b1;
                     else            m_err  = 1'b1;
                  end
`else
                  if (n == 4 * len) begin
                     m_active = 1'b0;
                     m_done   = 1'b1;
                  end
`endif
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare and write capture ----------------
   logic [31:0] cap_addr[$];
   logic [31:0] cap_data[$];
   logic        prev_wr = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         checks++;
         if (in_ready !== m_active || wr_en !== m_wr_en || wr_addr !== m_addr ||
             wr_data !== m_data || cpu_hold !== !m_done || done !== m_done ||
             error !== m_err) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b want rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b",
                     $time, in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error,
                     m_active, m_wr_en, m_addr, m_data, !m_done, m_done, m_err);
         end
         if (wr_en) begin
            $display("write addr=%h data=%h t=%0t", wr_addr, wr_data, $time);
            cap_addr.push_back(wr_addr);
            cap_data.push_back(wr_data);
            checks++;
            if (prev_wr) begin
               errors++;
               $display("FAIL wr_en_width t=%0t got 2+ cycles want 1", $time);
            end
         end
         prev_wr = wr_en;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end else begin
         $display("ok   %s = %h", name, got);
      end
   endtask

   task automatic clear_cap();
      cap_addr.delete();
      cap_data.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      idle(1);
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      bit ok = 1'b0;
      in_valid = 1'b0;
      idle(gap);
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout byte=%h got no ready want ready within 20 cycles", b);
      end
   endtask

   logic [7:0] basic[9] = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h03};

   task automatic load_basic(input int maxgap, input bit start_mid);
      pulse_start();
      for (int i = 0; i < 9; i++) begin
         if (start_mid && i == 3) pulse_start();
         send(basic[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h07, 0);
`endif
      idle(2);
   endtask

   task automatic check_basic(input string tag);
      check({tag, "_nwrites"}, 32'(cap_addr.size()), 32'd2);
      check({tag, "_addr0"}, cap_addr[0], 32'h0000_0000);
      check({tag, "_data0"}, cap_data[0], 32'h2008_0005);
      check({tag, "_addr1"}, cap_addr[1], 32'h0000_0004);
      check({tag, "_data1"}, cap_data[1], 32'h2009_0003);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
      check({tag, "_error"}, 32'(error), 32'd0);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      logic [7:0] xs;
      logic [7:0] w8;
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      idle(3);
      check("reset_cpu_hold", 32'(cpu_hold), 32'd1);
      check("reset_in_ready", 32'(in_ready), 32'd0);
      check("reset_wr_addr", wr_addr, 32'd0);
      reset = 1'b0;
      idle(2);

      // basic back-to-back load
      clear_cap();
      load_basic(0, 1'b0);
      check_basic("basic");

      // stalled stream, with an ignored start mid-load
      clear_cap();
      load_basic(3, 1'b1);
      check_basic("stall");

      // bad length 0
      clear_cap();
      pulse_start();
      send(8'h00, 0);
      idle(2);
      check("len0_error", 32'(error), 32'd1);
      check("len0_nwrites", 32'(cap_addr.size()), 32'd0);
      check("len0_cpu_hold", 32'(cpu_hold), 32'd1);

      // bad length 65
      pulse_start();
      send(8'd65, 0);
      idle(2);
      check("len65_error", 32'(error), 32'd1);
      check("len65_done", 32'(done), 32'd0);

      // recovery after error
      clear_cap();
      load_basic(0, 1'b0);
      check_basic("recover");

      // maximum length load
      clear_cap();
      xs = 8'h00;
      pulse_start();
      send(8'd64, 0);
      for (int w = 0; w < 64; w++) begin
         w8 = 8'(w);
         send(w8, 0);
         send(w8 ^ 8'h5A, 0);
         send(8'hC3, 0);
         send(~w8, 0);
         xs = xs ^ w8 ^ (w8 ^ 8'h5A) ^ 8'hC3 ^ ~w8;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(xs, 0);
`endif
      idle(2);
      check("max_nwrites", 32'(cap_addr.size()), 32'd64);
      check("max_addr63", cap_addr[63], 32'h0000_00FC);
      check("max_data63", cap_data[63], 32'h3F65_C3C0);
      check("max_done", 32'(done), 32'd1);

      // reset after 5 data bytes
      pulse_start();
      for (int i = 0; i < 6; i++) send(basic[i], 0);
      do_reset();
      clear_cap();
      idle(4);
      check("midrst_nwrites", 32'(cap_addr.size()), 32'd0);
      check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("midrst_done", 32'(done), 32'd0);
      clear_cap();
      load_basic(0, 1'b0);
      check_basic("after_rst");

`ifdef IMEM_LOADER_CHECKSUM_EN
      // checksum mismatch
      clear_cap();
      pulse_start();
      for (int i = 0; i < 9; i++) send(basic[i], 0);
      send(8'h08, 0);
      idle(2);
      check("csum_bad_error", 32'(error), 32'd1);
      check("csum_bad_cpu_hold", 32'(cpu_hold), 32'd1);
      check("csum_bad_nwrites", 32'(cap_addr.size()), 32'd2);
`endif

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the processor's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and issues one word write per instruction into the instruction memory's write port. The CPU is held in reset until a complete load finishes. It sits between the host/debug byte source and the instruction memory. It is the writer counterpart of the memory's combinational read port.

## Interface
- DEPTH, 64, instruction memory depth in words; maximum load length
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR
- `in_data`  in  8  stream byte
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  loader accepts a byte; a transfer occurs when `in_valid && in_ready`
- `wr_en`  out  1  one-cycle write strobe to the instruction memory
- `wr_addr`  out  32  byte address, word aligned (`word_index << 2`)
- `wr_data`  out  32  instruction word
- `cpu_hold`  out  1  holds the CPU in reset while high
- `done`  out  1  the last load completed successfully (level)
- `error`  out  1  the last load failed (level)

## Operation
- States: IDLE, LEN, DATA, (CSUM), DONE, ERROR.
- **IDLE**
  - `start` -> LEN.
  - `in_ready`=0.
- **LEN**
  - `in_ready`=1.
  - The accepted byte is L, the number of words.
  - L==0 or L>DEPTH -> ERROR.
  - Otherwise store L, clear word index and byte counter -> DATA.
- **DATA**
  - `in_ready`=1.
  - Bytes arrive MSB first. Byte k of a word goes to bits `[31-8k -: 8]`.
  - On the 4th accepted byte, the assembled word is registered. `wr_en`, `wr_addr` and `wr_data` are driven the following cycle.
  - The word index then increments.
  - After word L-1 is accepted -> CSUM if enabled, else DONE.
- **DONE**
  - `done`=1, `cpu_hold`=0, `in_ready`=0.
  - `start` -> LEN, clearing `done` and re-asserting `cpu_hold`.
- **ERROR**
  - `error`=1, `cpu_hold`=1, `in_ready`=0.
  - `start` -> LEN and clears `error`.
- `start` in LEN, DATA or CSUM is ignored.
- Bytes offered while `in_ready`=0 are ignored.
- `wr_addr` and `wr_data` hold their last values when `wr_en`=0.
- Words already written before an error are not rolled back.
- Internal byte counter is 2 bits; word index is `$clog2(DEPTH)+1` bits.

## Timing
- Reset values (asynchronous):
  - state=IDLE
  - `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0
  - `cpu_hold`=1, `done`=0, `error`=0
- `start` sampled at cycle t -> `in_ready`=1 at t+1.
- Byte throughput: one byte per cycle. `in_ready` stays 1 throughout LEN, DATA and CSUM, including the `wr_en` cycle.
- Write latency: `wr_en` is high exactly 1 cycle, at the cycle after the 4th byte handshake.
- Completion:
  - With checksum disabled, `done`=1 and `cpu_hold`=0 from the same cycle as the final `wr_en`. The CPU is released only after the final write edge.
  - With checksum enabled, `done` rises the cycle after the checksum byte handshake. This is never before the final write.
- `in_valid` gaps of any length stall assembly without affecting the outputs.
- Reset mid-load:
  - Immediately returns to reset values.
  - Any partial word is discarded; no further writes occur.
  - The next load starts at address 0.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the last data byte, the CSUM state accepts one byte and compares it with the running XOR of all data bytes. The length byte is excluded.
  - Match -> DONE.
  - Mismatch -> ERROR; `cpu_hold` stays 1.
- Undefined: no CSUM state, no checksum byte; DATA goes straight to DONE.

## Test plan
- **Reset:** assert `reset` mid-simulation -> `cpu_hold`=1, all other outputs 0, `in_ready`=0.
- **Basic load:** `start`, then L=2, then bytes 20 08 00 05 20 09 00 03 back-to-back. Required:
  - `wr_en` at `wr_addr`=0x0, `wr_data`=0x20080005.
  - `wr_en` at `wr_addr`=0x4, `wr_data`=0x20090003.
  - `done`=1 and `cpu_hold`=0 afterwards.
- **Stalled stream:** same stream as the basic load, with 0-3 random idle cycles between bytes -> identical writes; `wr_en` is never high for more than 1 cycle.
- **Bad length:** L=0 -> `error`=1, no `wr_en`. L=65 -> `error`=1. A following `start` with a valid stream -> `error` clears and the load completes.
- **Reset mid-load:** `reset` after 5 data bytes -> no further writes, `cpu_hold`=1. A new load writes the first word at address 0.
- **Checksum (macro defined):** the basic stream plus checksum byte 0x07 -> `done`=1. Checksum byte 0x08 -> `error`=1 and `cpu_hold`=1, with both words already written.
